// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   Decodes one TMDS channel from 10-bit deserialized symbols (one per
//   pixel clock) into 8b video bytes, 2b control codes and TERC4 nibbles,
//   and runs the word-alignment loop that requests deserializer bit slips.
//
// Ports
//   clk_pixel   in   pixel clock, all logic on rising edge
//   reset       in   synchronous, active-high
//   sym[9:0]    in   received symbol, bit 0 first on the wire
//   vid_pre     in   video preamble seen on ch1/ch2 (level, control period)
//   bitslip     out  one-cycle request to rotate alignment by one bit
//   locked      out  alignment acquired
//   de          out  data holds a video pixel byte
//   data[7:0]   out  decoded video byte
//   ctrl_valid  out  symbol was a control token
//   ctrl[1:0]   out  {c1,c0} of the control token
//   terc4_valid out  symbol decoded as TERC4 inside a data island
//   terc4[3:0]  out  TERC4 nibble
//   guard       out  second video guard-band symbol seen
//
// Alignment FSM
//   state    | meaning
//   SEARCH   | counting control-token runs, window timer running
//   SLIP     | settling after a bitslip request
//   LOCKED   | aligned, watchdog restarted by every control token
// Period FSM (forced to BLANK unless aligned)
//   BLANK    | control period, latching vid_pre on each token
//   VGUARD   | first video guard symbol seen
//   VIDEO    | active video pixels
//   ISLAND   | data island, TERC4 decode
// All outputs are registered: one cycle of latency from sym.

module tmds_channel_decoder #(
    parameter logic [9:0] GUARD         = 10'b1011001100,
    parameter int         LOCK_TOKENS   = 8,
    parameter int         SEARCH_WINDOW = 2048,
    parameter int         SLIP_WAIT     = 4
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] sym,
    input  logic       vid_pre,
    output logic       bitslip,
    output logic       locked,
    output logic       de,
    output logic [7:0] data,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       terc4_valid,
    output logic [3:0] terc4,
    output logic       guard
);

    localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
    localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
    localparam int SLP_W = $clog2(SLIP_WAIT + 2);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_TOKENS);
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(SEARCH_WINDOW);
    localparam logic [SLP_W-1:0] SLP_MAX = SLP_W'(SLIP_WAIT);

    localparam logic [1:0] A_SEARCH = 2'd0;
    localparam logic [1:0] A_SLIP   = 2'd1;
    localparam logic [1:0] A_LOCKED = 2'd2;

    localparam logic [1:0] P_BLANK  = 2'd0;
    localparam logic [1:0] P_VGUARD = 2'd1;
    localparam logic [1:0] P_VIDEO  = 2'd2;
    localparam logic [1:0] P_ISLAND = 2'd3;

    logic [1:0]       align_q, align_d;
    logic [1:0]       period_q, period_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [WIN_W-1:0] win_q, win_d, win_inc;
    logic [SLP_W-1:0] slp_q, slp_d;
    logic             pre_q, pre_d;

    logic       bitslip_q, bitslip_d;
    logic       locked_q, locked_d;
    logic       de_q, de_d;
    logic [7:0] data_q, data_d;
    logic       ctrl_valid_q, ctrl_valid_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       terc4_valid_q, terc4_valid_d;
    logic [3:0] terc4_q, terc4_d;
    logic       guard_q, guard_d;

    logic       is_ctrl, is_terc4, active, in_island;
    logic [1:0] ctrl_code;
    logic [3:0] terc4_code;
    logic [7:0] q8, dec8;

    always_comb begin
        is_ctrl   = 1'b1;
        ctrl_code = 2'd0;
        case (sym)
            10'b1101010100: ctrl_code = 2'd0;
            10'b0010101011: ctrl_code = 2'd1;
            10'b0101010100: ctrl_code = 2'd2;
            10'b1010101011: ctrl_code = 2'd3;
            default:        is_ctrl   = 1'b0;
        endcase
    end

    always_comb begin
        is_terc4   = 1'b1;
        terc4_code = 4'd0;
        case (sym)
            10'b1010011100: terc4_code = 4'd0;
            10'b1001100011: terc4_code = 4'd1;
            10'b1011100100: terc4_code = 4'd2;
            10'b1011100010: terc4_code = 4'd3;
            10'b0101110001: terc4_code = 4'd4;
            10'b0100011110: terc4_code = 4'd5;
            10'b0110001110: terc4_code = 4'd6;
            10'b0100111100: terc4_code = 4'd7;
            10'b1011001100: terc4_code = 4'd8;
            10'b0100111001: terc4_code = 4'd9;
            10'b0110011100: terc4_code = 4'd10;
            10'b1011000110: terc4_code = 4'd11;
            10'b1010001110: terc4_code = 4'd12;
            10'b1001110001: terc4_code = 4'd13;
            10'b0101100011: terc4_code = 4'd14;
            10'b1011000011: terc4_code = 4'd15;
            default:        is_terc4   = 1'b0;
        endcase
    end

    // sym[9] undoes the DC-balance inversion, sym[8] selects XOR/XNOR chaining.
    always_comb begin
        q8      = sym[9] ? ~sym[7:0] : sym[7:0];
        dec8    = 8'd0;
        dec8[0] = q8[0];
        for (int i = 1; i < 8; i++) begin
            dec8[i] = sym[8] ? (q8[i] ^ q8[i-1]) : ~(q8[i] ^ q8[i-1]);
        end
    end

    assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    assign win_inc = (win_q == WIN_MAX) ? win_q : win_q + 1'b1;

    // Alignment: win_q is the search window in SEARCH and the watchdog in LOCKED.
    always_comb begin
        align_d   = align_q;
        run_d     = run_q;
        win_d     = win_q;
        slp_d     = slp_q;
        bitslip_d = 1'b0;
        case (align_q)
            A_SEARCH: begin
                run_d = is_ctrl ? run_inc : '0;
                win_d = win_inc;
                if (is_ctrl && run_inc == RUN_MAX) begin
                    align_d = A_LOCKED;
                    run_d   = '0;
                    win_d   = '0;
                end else if (win_inc == WIN_MAX) begin
                    align_d   = A_SLIP;
                    bitslip_d = 1'b1;
                    run_d     = '0;
                    win_d     = '0;
                    slp_d     = '0;
                end
            end
            A_SLIP: begin
                // SLIP_WAIT settle cycles plus one cycle to restart the search.
                if (slp_q == SLP_MAX) begin
                    align_d = A_SEARCH;
                    run_d   = '0;
                    win_d   = '0;
                    slp_d   = '0;
                end else begin
                    slp_d = slp_q + 1'b1;
                end
            end
            A_LOCKED: begin
                if (is_ctrl) begin
                    win_d = '0;
                end else begin
                    win_d = win_inc;
                    if (win_inc == WIN_MAX) begin
                        align_d = A_SEARCH;
                        run_d   = '0;
                        win_d   = '0;
                    end
                end
            end
            default: align_d = A_SEARCH;
        endcase
    end

    // Period decode only runs while alignment holds through this cycle, so a
    // lock loss already blanks the outputs of the symbol that caused it.
    assign active = (align_q == A_LOCKED) && (align_d == A_LOCKED);

    always_comb begin
        period_d = period_q;
        pre_d    = is_ctrl ? vid_pre : pre_q;
        if (!active || is_ctrl) begin
            period_d = P_BLANK;
        end else begin
            case (period_q)
                P_BLANK: begin
                    if (pre_q && sym == GUARD) period_d = P_VGUARD;
                    else if (!pre_q)           period_d = P_ISLAND;
                end
                P_VGUARD: period_d = (sym == GUARD) ? P_VIDEO : P_BLANK;
                default:  period_d = period_q;
            endcase
        end
    end

    // The first island symbol is decoded in the same cycle that enters ISLAND.
    assign in_island = active && !is_ctrl &&
                       (period_q == P_ISLAND || period_d == P_ISLAND);

    always_comb begin
        locked_d      = (align_d == A_LOCKED);
        ctrl_valid_d  = is_ctrl;
        ctrl_d        = is_ctrl ? ctrl_code : 2'd0;
        de_d          = active && !is_ctrl && (period_q == P_VIDEO);
        data_d        = de_d ? dec8 : 8'd0;
        terc4_valid_d = in_island && is_terc4;
        terc4_d       = terc4_valid_d ? terc4_code : 4'd0;
        guard_d       = active && !is_ctrl && (period_q == P_VGUARD) && (sym == GUARD);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            align_q       <= A_SEARCH;
            period_q      <= P_BLANK;
            run_q         <= '0;
            win_q         <= '0;
            slp_q         <= '0;
            pre_q         <= 1'b0;
            bitslip_q     <= 1'b0;
            locked_q      <= 1'b0;
            de_q          <= 1'b0;
            data_q        <= 8'd0;
            ctrl_valid_q  <= 1'b0;
            ctrl_q        <= 2'd0;
            terc4_valid_q <= 1'b0;
            terc4_q       <= 4'd0;
            guard_q       <= 1'b0;
        end else begin
            align_q       <= align_d;
            period_q      <= period_d;
            run_q         <= run_d;
            win_q         <= win_d;
            slp_q         <= slp_d;
            pre_q         <= pre_d;
            bitslip_q     <= bitslip_d;
            locked_q      <= locked_d;
            de_q          <= de_d;
            data_q        <= data_d;
            ctrl_valid_q  <= ctrl_valid_d;
            ctrl_q        <= ctrl_d;
            terc4_valid_q <= terc4_valid_d;
            terc4_q       <= terc4_d;
            guard_q       <= guard_d;
        end
    end

    assign bitslip     = bitslip_q;
    assign locked      = locked_q;
    assign de          = de_q;
    assign data        = data_q;
    assign ctrl_valid  = ctrl_valid_q;
    assign ctrl        = ctrl_q;
    assign terc4_valid = terc4_valid_q;
    assign terc4       = terc4_q;
    assign guard       = guard_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder
//   Scoreboarded bench for tmds_channel_decoder. Directed phases push the
//   expected output word when a symbol is driven and pop/compare it after
//   the edge that registers it. Video symbols come from a reference TMDS
//   encoder with running disparity; the alignment phase models a
//   deserializer that rotates its word boundary on every bitslip pulse.

module tb_tmds_channel_decoder;

    localparam logic [9:0] GUARD_SYM = 10'b1011001100;
    localparam logic [9:0] CTL0      = 10'b1101010100;
    localparam logic [9:0] CTL1      = 10'b0010101011;
    localparam logic [9:0] CTL2      = 10'b0101010100;
    localparam logic [9:0] CTL3      = 10'b1010101011;
    localparam int         MIN_GAP   = 2048 + 4 + 1;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic [9:0] sym;
    logic       vid_pre;
    logic       bitslip, locked, de, ctrl_valid, terc4_valid, guard;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [3:0] terc4;

    always #5 clk_pixel = ~clk_pixel;

    tmds_channel_decoder #(
        .GUARD         (GUARD_SYM),
        .LOCK_TOKENS   (8),
        .SEARCH_WINDOW (2048),
        .SLIP_WAIT     (4)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .sym         (sym),
        .vid_pre     (vid_pre),
        .bitslip     (bitslip),
        .locked      (locked),
        .de          (de),
        .data        (data),
        .ctrl_valid  (ctrl_valid),
        .ctrl        (ctrl),
        .terc4_valid (terc4_valid),
        .terc4       (terc4),
        .guard       (guard)
    );

    // {bitslip, locked, de, data, ctrl_valid, ctrl, terc4_valid, terc4, guard}
    logic [19:0] out_vec;
    assign out_vec = {bitslip, locked, de, data, ctrl_valid, ctrl, terc4_valid, terc4, guard};

    typedef struct {
        string       tag;
        logic [19:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_run  = 0;
    int  n_fail = 0;
    int  disp   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ex(input logic lk, input logic de_e, input logic [7:0] d,
                                       input logic cv, input logic [1:0] c, input logic tv,
                                       input logic [3:0] t, input logic g);
        return {1'b0, lk, de_e, d, cv, c, tv, t, g};
    endfunction

    function automatic logic [19:0] e_ctrl(input logic [1:0] c, input logic lk);
        return ex(lk, 1'b0, 8'd0, 1'b1, c, 1'b0, 4'd0, 1'b0);
    endfunction

    function automatic logic [19:0] e_idle(input logic lk);
        return ex(lk, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
    endfunction

    function automatic logic [19:0] e_pix(input logic [7:0] d);
        return ex(1'b1, 1'b1, d, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
    endfunction

    function automatic logic [19:0] e_terc(input logic [3:0] t);
        return ex(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b1, t, 1'b0);
    endfunction

    // Word seen by a deserializer whose boundary is off by 'off' bits.
    function automatic logic [9:0] rot(input logic [9:0] t, input int off);
        logic [19:0] w;
        w = {t, t};
        return w[19-off -: 10];
    endfunction

    // Reference DVI/TMDS 8b/10b encoder with running disparity.
    task automatic enc(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1d, n1q, n0q;
        n1d   = $countones(d);
        qm    = 9'd0;
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8] == 1'b0) disp += n0q - n1q;
            else               disp += n1q - n0q;
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp += -2 * int'(!qm[8]) + n1q - n0q;
        end
    endtask

    task automatic step(input logic [9:0] s, input logic pre, input logic rst,
                        input logic [19:0] e, input string tag);
        sb_t it;
        sym     = s;
        vid_pre = pre;
        reset   = rst;
        it.tag  = tag;
        it.exp  = e;
        sb_q.push_back(it);
        @(posedge clk_pixel);
        #1;
        it = sb_q.pop_front();
        check(it.tag, {12'd0, out_vec}, {12'd0, it.exp});
    endtask

    initial begin
        logic [9:0]  s;
        logic [7:0]  b;
        logic [7:0]  pix[4];
        int          n_wd, offset, pulses, last, min_gap;
        logic        seen;

        reset   = 1'b1;
        sym     = CTL0;
        vid_pre = 1'b0;

        step(CTL0, 1'b0, 1'b1, 20'd0, "reset");

        for (int i = 0; i < 8; i++)
            step(CTL0, 1'b0, 1'b0, e_ctrl(2'd0, i == 7), "lock_run");

        // Video period: preamble, two guards, four pixels, closing token.
        for (int i = 0; i < 8; i++)
            step(CTL0, 1'b1, 1'b0, e_ctrl(2'd0, 1'b1), "vid_preamble");
        disp = 0;
        step(GUARD_SYM, 1'b1, 1'b0, e_idle(1'b1), "guard1");
        step(GUARD_SYM, 1'b1, 1'b0, ex(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1), "guard2");
        pix = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            enc(pix[i], s);
            step(s, 1'b1, 1'b0, e_pix(pix[i]), "video_pix");
        end
        step(CTL1, 1'b1, 1'b0, e_ctrl(2'd1, 1'b1), "vid_end_ctrl");

        // Guard band broken by a foreign symbol: no video, back to blank.
        step(GUARD_SYM, 1'b1, 1'b0, e_idle(1'b1), "abort_guard");
        step(10'b1010011100, 1'b1, 1'b0, e_idle(1'b1), "abort_vguard");
        step(10'b1010011100, 1'b1, 1'b0, e_idle(1'b1), "blank_stay");

        // Data island.
        step(CTL2, 1'b0, 1'b0, e_ctrl(2'd2, 1'b1), "isl_ctrl");
        step(10'b1011100010, 1'b0, 1'b0, e_terc(4'd3), "terc4_3");
        step(10'b1011000011, 1'b0, 1'b0, e_terc(4'd15), "terc4_15");
        step(10'b0000011111, 1'b0, 1'b0, e_idle(1'b1), "terc4_bad");
        step(CTL3, 1'b0, 1'b0, e_ctrl(2'd3, 1'b1), "isl_end_ctrl");

        // Endless video: watchdog counts every non-control symbol since the token.
        step(CTL0, 1'b1, 1'b0, e_ctrl(2'd0, 1'b1), "wd_ctrl");
        disp = 0;
        step(GUARD_SYM, 1'b1, 1'b0, e_idle(1'b1), "wd_guard1");
        step(GUARD_SYM, 1'b1, 1'b0, ex(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1), "wd_guard2");
        n_wd = 2;
        for (int k = 0; k < 2048; k++) begin
            b = 8'($urandom_range(0, 255));
            enc(b, s);
            n_wd++;
            if (n_wd < 2048) step(s, 1'b1, 1'b0, e_pix(b), "wd_video");
            else             step(s, 1'b1, 1'b0, e_idle(1'b0), "wd_lost");
        end

        // Relock, enter video, then reset mid-pixel.
        for (int i = 0; i < 8; i++)
            step(CTL0, 1'b1, 1'b0, e_ctrl(2'd0, i == 7), "relock_run");
        disp = 0;
        step(GUARD_SYM, 1'b1, 1'b0, e_idle(1'b1), "rv_guard1");
        step(GUARD_SYM, 1'b1, 1'b0, ex(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1), "rv_guard2");
        enc(8'h11, s);
        step(s, 1'b1, 1'b0, e_pix(8'h11), "rv_pix");
        enc(8'h22, s);
        step(s, 1'b1, 1'b0, e_pix(8'h22), "rv_pix");
        enc(8'h33, s);
        step(s, 1'b1, 1'b1, 20'd0, "rst_in_video");
        for (int i = 0; i < 8; i++)
            step(CTL0, 1'b1, 1'b0, e_ctrl(2'd0, i == 7), "post_rst_run");

        // Stream rotated by 3 bits: three slips, then lock.
        step(CTL0, 1'b0, 1'b1, 20'd0, "reset2");
        offset  = 3;
        pulses  = 0;
        last    = -1;
        min_gap = 1 << 30;
        for (int c = 0; c < 9000 && !locked; c++) begin
            sym     = rot(CTL0, offset);
            vid_pre = 1'b0;
            reset   = 1'b0;
            @(posedge clk_pixel);
            #1;
            if (bitslip) begin
                pulses++;
                if (last >= 0 && (c - last) < min_gap) min_gap = c - last;
                last   = c;
                offset = (offset == 0) ? 9 : offset - 1;
            end
        end
        check("slip_count", 32'(pulses), 32'd3);
        check("slip_gap_ok", {31'd0, min_gap >= MIN_GAP}, 32'd1);
        check("slip_locked", {31'd0, locked}, 32'd1);

        // Reset during SLIP aborts it; relock needs a full fresh run.
        step(CTL0, 1'b0, 1'b1, 20'd0, "reset3");
        offset = 3;
        seen   = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            sym     = rot(CTL0, offset);
            vid_pre = 1'b0;
            reset   = 1'b0;
            @(posedge clk_pixel);
            #1;
            seen = bitslip;
        end
        check("slip1_seen", {31'd0, seen}, 32'd1);
        step(CTL0, 1'b0, 1'b1, 20'd0, "rst_in_slip");
        for (int i = 0; i < 8; i++)
            step(CTL0, 1'b0, 1'b0, e_ctrl(2'd0, i == 7), "post_slip_run");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the HDMI/TMDS transmit path: decodes one TMDS channel from 10-bit parallel symbols (already deserialized at pixel rate) back into 8-bit video data, 2-bit control and 4-bit TERC4 data-island nibbles. It also runs the word-alignment state machine and requests bit slips from the deserializer. Three instances, one per channel, sit behind the ISERDES in the HDMI receive/loopback path. Control outputs of channels 1/2 feed the preamble decode that drives `vid_pre`.

## Interface
- `GUARD`, 10'b1011001100 — video guard-band code for this channel (ch0/ch2: 1011001100, ch1: 0100110011)
- `LOCK_TOKENS`, 8 — consecutive control tokens required to declare lock
- `SEARCH_WINDOW`, 2048 — symbols without a qualifying control run before a slip (SEARCH) or lock loss (LOCKED)
- `SLIP_WAIT`, 4 — settle cycles after a bitslip pulse

Ports:
- `clk_pixel` in 1 — pixel clock; all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `sym` in 10 — received symbol, bit 0 first on the wire; one new symbol per cycle
- `vid_pre` in 1 — video preamble detected on ch1/ch2 (CTL3..0=0001), level, valid during control period
- `bitslip` out 1 — one-cycle pulse: rotate deserializer alignment by one bit
- `locked` out 1 — alignment acquired
- `de` out 1 — `data` is a video pixel byte
- `data` out 8 — decoded 8b video byte
- `ctrl_valid` out 1 — symbol was a control token
- `ctrl` out 2 — {c1,c0} of control token
- `terc4_valid` out 1 — symbol decoded as TERC4 inside a data island
- `terc4` out 4 — TERC4 nibble
- `guard` out 1 — symbol equals `GUARD` while in the guard state

## Operation
- Control tokens: 1101010100→00, 0010101011→01, 0101010100→10, 1010101011→11.
- 8b decode: q[7:0] = sym[9] ? ~sym[7:0] : sym[7:0]; d[0]=q[0]; d[i] = sym[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]), i=1..7.
- TERC4, codes 0..15: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011. A non-matching symbol in an island gives terc4_valid=0.
- Alignment FSM, states SEARCH, SLIP, LOCKED:
  - SEARCH: run counter increments on each control token and clears on any other symbol. When run reaches LOCK_TOKENS → LOCKED. The window counter counts every symbol; at SEARCH_WINDOW → SLIP with a bitslip pulse that cycle.
  - SLIP: wait SLIP_WAIT cycles, clear all counters → SEARCH.
  - LOCKED: watchdog clears on every control token. At SEARCH_WINDOW → SEARCH with no slip, `locked` drops.
- Period FSM, states BLANK, VGUARD, VIDEO, ISLAND; active only in LOCKED, otherwise forced BLANK:
  - BLANK: each control token latches `vid_pre`. On a non-control symbol: if the latch is 1 and sym==GUARD → VGUARD (count 1); if the latch is 0 → ISLAND; otherwise stay in BLANK.
  - VGUARD: second GUARD → VIDEO; any other symbol → BLANK.
  - VIDEO: every non-control symbol gives de=1 with 8b decode; a control token → BLANK.
  - ISLAND: TERC4 decode; a control token → BLANK.
- Control token has priority in all states: ctrl_valid=1, de=0.

## Timing
- All outputs registered; they reflect `sym` sampled at edge N and are visible after edge N (latency 1 cycle).
- The first video pixel's de=1 occurs one cycle after the second guard symbol's output.
- Reset: all outputs 0, both FSMs to SEARCH/BLANK, counters 0, preamble latch 0. Reset mid-operation aborts immediately, including during SLIP; no bitslip is issued in the reset cycle.
- bitslip is never asserted in two consecutive cycles; minimum spacing is SEARCH_WINDOW+SLIP_WAIT+1.
- Lock loss in VIDEO/ISLAND: the same cycle's outputs already use forced BLANK (de=0, terc4_valid=0).
- Counters saturate; no wrap. The window counter is wide enough for SEARCH_WINDOW.

## Test plan
- Aligned stream: 8× 1101010100 → locked=1 after the 8th token's output, ctrl=00, ctrl_valid=1, bitslip never asserted.
- Stream rotated by 3 bits → exactly 3 bitslip pulses spaced ≥ SEARCH_WINDOW+SLIP_WAIT+1, then locked=1; model deserializer rotates on each pulse.
- Locked, vid_pre=1, 8 control tokens, 2× GUARD, then encoder output for bytes 0x00, 0xFF, 0xA5, 0x5A → de=1 with data 0x00, 0xFF, 0xA5, 0x5A; de=0 on the following control token.
- Locked, vid_pre=0, then 1011100010 and 1011000011 → terc4_valid=1, terc4=3, then 15; de=0.
- Locked, then 2048 symbols of video data with no control token → locked falls, de=0, no bitslip.
- Assert reset during SLIP and during VIDEO → all outputs 0 next cycle; relock needs a fresh 8-token run.
